// File: rtl/pa_pkg.sv
// Shared types for the pa memory arbiter: request/response bundles, FSM state
// and requester identifiers.
package pa_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned PHY_ADDR_LEN = 32;
  localparam int unsigned NUM_SRC      = 3;

  typedef struct packed {
    logic                    valid;
    logic [PHY_ADDR_LEN-1:0] addr;
  } if_req_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rdata;
  } if_resp_t;

  typedef struct packed {
    logic                    valid;
    logic [PHY_ADDR_LEN-1:0] addr;
  } m_read_req_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rdata;
  } m_read_resp_t;

  typedef struct packed {
    logic                    valid;
    logic [PHY_ADDR_LEN-1:0] addr;
    logic [XLEN-1:0]         wdata;
  } m_write_req_t;

  typedef struct packed {
    logic valid;
  } m_write_resp_t;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

  typedef enum logic [1:0] {
    SRC_IF  = 2'd0,
    SRC_MRD = 2'd1,
    SRC_MWR = 2'd2
  } arb_src_t;

  function automatic arb_src_t onehot_to_src(input logic [NUM_SRC-1:0] grant);
    if (grant[SRC_MWR]) return SRC_MWR;
    if (grant[SRC_MRD]) return SRC_MRD;
    return SRC_IF;
  endfunction

endpackage

// File: rtl/pa_arb_pick.sv
// Combinational winner selection. PA_MEM_ARB_RR_EN selects round-robin after
// i_last; otherwise fixed write > read > fetch with a starvation override.
module pa_arb_pick
  import pa_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic [NUM_SRC-1:0] i_pending,
  input  arb_src_t           i_last,
  input  logic [CNT_W-1:0]   i_cnt,
  output logic [NUM_SRC-1:0] o_grant
);

`ifdef PA_MEM_ARB_RR_EN
  logic [1:0] w_idx;
  logic       w_unused_cnt;
  assign w_unused_cnt = ^i_cnt;

  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      w_idx = 2'((32'(i_last) + k) % NUM_SRC);
      if (o_grant == '0 && i_pending[w_idx]) o_grant[w_idx] = 1'b1;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^{i_last};

  always_comb begin
    o_grant = '0;
    if (i_pending[SRC_IF] && i_cnt == CNT_W'(STARVE_LIMIT)) o_grant[SRC_IF] = 1'b1;
    else if (i_pending[SRC_MWR])                             o_grant[SRC_MWR] = 1'b1;
    else if (i_pending[SRC_MRD])                             o_grant[SRC_MRD] = 1'b1;
    else if (i_pending[SRC_IF])                              o_grant[SRC_IF] = 1'b1;
  end
`endif

endmodule

// File: rtl/pa_mem_arbiter.sv
// Single-outstanding arbiter of fetch, data-read and data-write onto one memory
// port. Define PA_MEM_ARB_RR_EN for round-robin instead of fixed priority.
module pa_mem_arbiter
  import pa_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  if_req_t                 if_req_i,
  output if_resp_t                if_resp_o,
  input  m_read_req_t             m_read_req_i,
  output m_read_resp_t            m_read_resp_o,
  input  m_write_req_t            m_write_req_i,
  output m_write_resp_t           m_write_resp_o,
  output logic                    mem_req_valid_o,
  output logic                    mem_req_we_o,
  output logic [PHY_ADDR_LEN-1:0] mem_req_addr_o,
  output logic [XLEN-1:0]         mem_req_wdata_o,
  input  logic                    mem_resp_valid_i,
  input  logic [XLEN-1:0]         mem_resp_rdata_i,
  output logic                    busy_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t              r_state, w_state_nxt;
  arb_src_t                r_owner, w_win, w_last;
  logic [NUM_SRC-1:0]      r_pend, w_req_v, w_grant;
  logic [PHY_ADDR_LEN-1:0] r_addr     [NUM_SRC];
  logic [PHY_ADDR_LEN-1:0] w_req_addr [NUM_SRC];
  logic [XLEN-1:0]         r_wdata;
  logic [CNT_W-1:0]        w_cnt;
  logic                    w_go, w_done;

  logic                    r_mem_valid, r_mem_we;
  logic [PHY_ADDR_LEN-1:0] r_mem_addr;
  logic [XLEN-1:0]         r_mem_wdata;
  if_resp_t                r_if_resp;
  m_read_resp_t            r_rd_resp;
  m_write_resp_t           r_wr_resp;

  assign w_req_v            = {m_write_req_i.valid, m_read_req_i.valid, if_req_i.valid};
  assign w_req_addr[SRC_IF]  = if_req_i.addr;
  assign w_req_addr[SRC_MRD] = m_read_req_i.addr;
  assign w_req_addr[SRC_MWR] = m_write_req_i.addr;

  pa_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .i_pending (r_pend),
    .i_last    (w_last),
    .i_cnt     (w_cnt),
    .o_grant   (w_grant)
  );

  assign w_win = onehot_to_src(w_grant);

  // A response coinciding with the request beat is spurious and ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ARB_IDLE: if (|r_pend) begin
        w_go        = 1'b1;
        w_state_nxt = ARB_WAIT;
      end
      ARB_WAIT: if (mem_resp_valid_i && !r_mem_valid) begin
        w_done      = 1'b1;
        w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ARB_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Pending slots: a pulse while the slot is still held is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend  <= '0;
      r_wdata <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) r_addr[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (w_done && 32'(r_owner) == i) begin
          r_pend[i] <= 1'b0;
        end else if (w_req_v[i] && !r_pend[i]) begin
          r_pend[i] <= 1'b1;
          r_addr[i] <= w_req_addr[i];
        end
      end
      if (m_write_req_i.valid && !r_pend[SRC_MWR]) r_wdata <= m_write_req_i.wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner     <= SRC_IF;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_resp   <= '0;
      r_rd_resp   <= '0;
      r_wr_resp   <= '0;
    end else begin
      r_mem_valid <= w_go;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_resp   <= '0;
      r_rd_resp   <= '0;
      r_wr_resp   <= '0;
      if (w_go) begin
        r_owner    <= w_win;
        r_mem_we   <= (w_win == SRC_MWR);
        r_mem_addr <= r_addr[w_win];
        if (w_win == SRC_MWR) r_mem_wdata <= r_wdata;
      end
      if (w_done) begin
        case (r_owner)
          SRC_IF:  r_if_resp <= '{valid: 1'b1, rdata: mem_resp_rdata_i};
          SRC_MRD: r_rd_resp <= '{valid: 1'b1, rdata: mem_resp_rdata_i};
          SRC_MWR: r_wr_resp <= '{valid: 1'b1};
          default: r_if_resp <= '0;
        endcase
      end
    end
  end

`ifdef PA_MEM_ARB_RR_EN
  arb_src_t r_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   r_last <= SRC_MWR;
    else if (w_go) r_last <= w_win;
  end

  assign w_last = r_last;
  assign w_cnt  = '0;
`else
  logic [CNT_W-1:0] r_cnt;

  // Consecutive data grants while a fetch waits; saturates at STARVE_LIMIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                         r_cnt <= '0;
    else if (!r_pend[SRC_IF] || (w_go && w_win == SRC_IF)) r_cnt <= '0;
    else if (w_go && r_cnt != CNT_W'(STARVE_LIMIT))        r_cnt <= r_cnt + CNT_W'(1);
  end

  assign w_last = SRC_MWR;
  assign w_cnt  = r_cnt;
`endif

  assign mem_req_valid_o = r_mem_valid;
  assign mem_req_we_o    = r_mem_we;
  assign mem_req_addr_o  = r_mem_addr;
  assign mem_req_wdata_o = r_mem_wdata;
  assign if_resp_o       = r_if_resp;
  assign m_read_resp_o   = r_rd_resp;
  assign m_write_resp_o  = r_wr_resp;
  assign busy_o          = (r_state == ARB_WAIT);

endmodule
